sigdel_interp: RTL
==================

SIGDEL_INTERP -- requirements
Module: sigdel_interp

Interface
REQ-001 Parameter BITLEN, default 16, sample and DAC code width in bits.
REQ-002 Parameter OSR_LOG2, default 6, log2 of clocks per input sample period (OSR = 2^OSR_LOG2).
REQ-003 Parameter FIFO_DEPTH, default 4, input sample buffer depth (power of two, >=2).
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 s_data  input  BITLEN  signed two's-complement audio sample.
REQ-007 s_valid  input  1  s_data valid.
REQ-008 s_ready  output  1  block can accept a sample this cycle.
REQ-009 dac_code  output  BITLEN  unsigned offset-binary code for the sigma-delta DAC input; changes at most once per clk.
REQ-010 underrun  output  1  sticky flag: a sample period started with an empty buffer.
REQ-011 clr_underrun  input  1  synchronous clear of underrun.

Function
REQ-012 A sample SHALL be written to the buffer on any clk edge where s_valid and s_ready are both 1; s_ready SHALL equal (buffer count < FIFO_DEPTH), derived only from registered count.
REQ-013 Simultaneous push and pop SHALL leave count unchanged; pushes when full SHALL be impossible via s_ready=0.
REQ-014 A phase counter of OSR_LOG2 bits SHALL increment every clk in RUN/HOLD and wrap from OSR-1 to 0; the wrap cycle is the period boundary.
REQ-015 States: IDLE, RUN, HOLD.
REQ-016 IDLE: target=0, step=0, phase=0; first cycle buffer non-empty SHALL pop, set step=sample-target, target=sample, phase=0, go to RUN.
REQ-017 At each boundary in RUN or HOLD with buffer non-empty: pop, step=(sample-target), target=sample, state RUN.
REQ-018 At a boundary with buffer empty: step=0, accumulator forced to target<<OSR_LOG2, underrun set, state HOLD.
REQ-019 Accumulator width BITLEN+OSR_LOG2+1 signed; step width BITLEN+1 signed; every non-boundary RUN cycle acc += step, so acc reaches target<<OSR_LOG2 exactly after OSR cycles with no overflow.
REQ-020 dac_code SHALL be registered: upper BITLEN bits of acc above the fractional bits, MSB inverted (signed-to-offset conversion); latency acc-to-dac_code 1 clk.
REQ-021 Ramp from old target to new target SHALL complete in exactly OSR clks after the pop; dac_code equals offset(new target) on the cycle before the next boundary's effect.
REQ-022 underrun: set per REQ-018; clr_underrun clears it; if both in same cycle, set wins.
REQ-023 Full-scale steps (e.g. -32768 to +32767) SHALL ramp monotonically without wrap.

Reset
REQ-024 On rst=1, asynchronously: state=IDLE, buffer empty, count=0, phase=0, acc=0, target=0, step=0, dac_code=2^(BITLEN-1) (midscale, 0x8000), underrun=0, s_ready=0 while rst asserted and 1 on the first cycle after.
REQ-025 Reset mid-ramp SHALL discard buffered samples; no partial state survives.

Structure
REQ-026 Package sigdel_pkg SHALL hold the state enum (IDLE/RUN/HOLD) and a midscale-code function/constant; parameters stay on the module.
REQ-027 Buffer SHALL be a sub-module sigdel_fifo (synchronous FIFO, registered count, full/empty flags, async active-high reset); interpolator/FSM stays in sigdel_interp.

Verification (BITLEN=16, OSR_LOG2=2, FIFO_DEPTH=4)
REQ-028 Reset release, no input -> dac_code=0x8000, s_ready=1, underrun=0 indefinitely in IDLE.
REQ-029 Push 0x0400 once -> dac_code steps 0x8100,0x8200,0x8300,0x8400 on consecutive clks, then underrun=1 and dac_code holds 0x8400.
REQ-030 Push 0x8000 (-32768) then 0x7FFF at full rate -> ramp to 0x0000 then monotonic rise to 0xFFFF, no wrap; underrun stays 0 while buffer non-empty.
REQ-031 Hold s_valid=1 with 6 samples and no drain opportunity -> s_ready falls after 4 accepted; no sample lost or duplicated in dac_code targets.
REQ-032 Assert rst mid-ramp with 3 samples buffered -> next clk dac_code=0x8000, state IDLE, buffer empty; clr_underrun with simultaneous underrun event -> underrun remains 1.

Source files
------------

// File: rtl/sigdel_pkg.sv
// Shared types and constants for the sigma-delta DAC interpolator.
// The FSM encoding lives here so that the interpolator and any observer use the same values.
package sigdel_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Offset-binary code for a zero-valued sample (0x8000 for a 16-bit code).
    function automatic logic [31:0] midscale(input int unsigned bitlen);
        return 32'd1 << (bitlen - 1);
    endfunction

endpackage

// File: rtl/sigdel_fifo.sv
// Synchronous show-ahead FIFO buffering incoming audio samples.
// rd_data always presents the oldest entry; push when full and pop when empty are ignored.
module sigdel_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    // Storage carries no reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sigdel_interp.sv
// Linear interpolator feeding a sigma-delta DAC: each buffered sample is reached by a
// straight-line ramp of 2^OSR_LOG2 equal steps, then held if the next sample is late.
module sigdel_interp
    import sigdel_pkg::*;
#(
    parameter int BITLEN     = 16,
    parameter int OSR_LOG2   = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BITLEN-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [BITLEN-1:0] dac_code,
    output logic              underrun,
    input  logic              clr_underrun,
    output logic [1:0]        fsm_state
);

    localparam int ACC_W  = BITLEN + OSR_LOG2 + 1;
    localparam int STEP_W = BITLEN + 1;
    localparam logic [OSR_LOG2-1:0] PHASE_LAST = '1;
    localparam logic [BITLEN-1:0]   MID_CODE   = BITLEN'(midscale(BITLEN));

    state_t              state;
    state_t              state_next;
    logic [OSR_LOG2-1:0] phase;
    logic [ACC_W-1:0]    acc;
    logic [STEP_W-1:0]   step;
    logic [BITLEN-1:0]   target;

    logic                fifo_full;
    logic                fifo_empty;
    logic [BITLEN-1:0]   head;
    logic                pop;
    logic                boundary;
    logic [STEP_W-1:0]   step_new;
    logic [ACC_W-1:0]    target_acc;
    logic [ACC_W-1:0]    step_ext;

    sigdel_fifo #(
        .WIDTH (BITLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (s_valid & s_ready),
        .wr_data (s_data),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Handshake: a sample transfers on any clk edge where s_valid && s_ready; s_ready
    // depends only on the registered buffer count (and is held low during reset).
    assign s_ready   = ~fifo_full & ~rst;
    assign fsm_state = state;

    assign boundary   = (state != IDLE) && (phase == PHASE_LAST);
    assign step_new   = {head[BITLEN-1], head} - {target[BITLEN-1], target};
    assign target_acc = {target[BITLEN-1], target, {OSR_LOG2{1'b0}}};
    assign step_ext   = {{OSR_LOG2{step[STEP_W-1]}}, step};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = RUN;
                end
            end
            RUN, HOLD: begin
                if (boundary) begin
                    state_next = fifo_empty ? HOLD : RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pop = 1'b0;
        case (state)
            IDLE:      pop = ~fifo_empty;
            RUN, HOLD: pop = boundary & ~fifo_empty;
            default:   pop = 1'b0;
        endcase
    end

    // At a boundary the accumulator snaps to the exact target, so rounding can never drift;
    // in HOLD the step is zero and the sum simply stays put.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase    <= '0;
            acc      <= '0;
            step     <= '0;
            target   <= '0;
            dac_code <= MID_CODE;
        end else begin
            dac_code <= {~acc[ACC_W-2], acc[ACC_W-3:OSR_LOG2]};
            if (state == IDLE) begin
                phase <= '0;
            end else begin
                phase <= phase + 1'b1;
                if (boundary) begin
                    acc <= target_acc;
                end else begin
                    acc <= acc + step_ext;
                end
            end
            if (pop) begin
                step   <= step_new;
                target <= head;
            end else if (boundary) begin
                step <= '0;
            end
        end
    end

    // A fresh underrun event outranks a clear arriving in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun <= 1'b0;
        end else if (boundary && fifo_empty) begin
            underrun <= 1'b1;
        end else if (clr_underrun) begin
            underrun <= 1'b0;
        end
    end

endmodule
